// File: rtl/demux5_pkg.sv
// Shared sizing, channel codes and select validation for the 5-way byte router.
package demux5_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NUM_CH = 5;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [SEL_W-1:0] {
        CH_A = 3'd0,
        CH_B = 3'd1,
        CH_C = 3'd2,
        CH_D = 3'd3,
        CH_E = 3'd4
    } ch_e;

    function automatic logic sel_is_valid(input logic [SEL_W-1:0] sel);
        return (32'(sel) < NUM_CH);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel with valid/ready handshake.
module demux_slot #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Load wins over consume so a same-cycle refill keeps the slot occupied.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/demux5_router.sv
// Routes one byte stream to five registered channels by manual select or round-robin.
module demux5_router
    import demux5_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     auto_mode,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic                     err_sel,
    output logic [CNT_W-1:0]         drop_count,
    output logic [SEL_W-1:0]         rr_ptr
);

    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [SEL_W-1:0]  target;
    logic              tgt_ok;
    logic              tgt_free;
    logic              accept;
    logic [NUM_CH-1:0] load;

    always_comb begin
        target = auto_mode ? rr_ptr_q : in_sel;
        tgt_ok = sel_is_valid(target);
    end

    // Invalid targets always accept so the bad byte can be dropped and counted.
    always_comb begin
        tgt_free = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (target == SEL_W'(k)) begin
                tgt_free = ~out_valid[k] | out_ready[k];
            end
        end
        in_ready = tgt_ok ? tgt_free : 1'b1;
        accept   = in_valid & in_ready;
    end

    always_comb begin
        load = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            load[k] = accept & tgt_ok & (target == SEL_W'(k));
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (!auto_mode) begin
            rr_ptr_d = '0;
        end else if (accept) begin
            rr_ptr_d = (rr_ptr_q == SEL_W'(NUM_CH - 1)) ? '0 : rr_ptr_q + SEL_W'(1);
        end
    end

    always_comb begin
        err_d  = accept & ~tgt_ok;
        drop_d = drop_q;
        if (err_d && (drop_q != '1)) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
            drop_q   <= drop_d;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk    (clk),
            .rst    (rst),
            .load_i (load[k]),
            .data_i (in_data),
            .ready_i(out_ready[k]),
            .valid_o(out_valid[k]),
            .data_o (out_data[k*DATA_W +: DATA_W])
        );
    end

    assign err_sel    = err_q;
    assign drop_count = drop_q;
    assign rr_ptr     = rr_ptr_q;

endmodule

// File: doc/demux5_router.md
Name: demux5_router

Overview:
- Distribution side of the 5-way 8-bit channel select used on the HPS-FPGA datapath: one byte stream in, routed to one of five registered output channels (A..E).
- A 3-bit select chooses the channel per byte (manual mode), or an internal round-robin pointer distributes bytes A->E cyclically (auto mode).
- Every channel has a one-entry holding register with a valid/ready handshake, so a stalled consumer blocks only its own channel.
- Sits between the HPS bridge write path and the per-operand consumers.

Parameters:
- DATA_W, 8, byte width of each channel.
- NUM_CH, 5, number of output channels (fixed at 5 for this design; select codes 0..4).
- SEL_W, 3, select width.
- CNT_W, 8, width of the dropped-byte counter.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DATA_W  input byte.
- in_sel  in  SEL_W  destination channel in manual mode; 0=A, 1=B, 2=C, 3=D, 4=E; 5..7 invalid.
- in_valid  in  1  input byte present.
- in_ready  out  1  router can accept this cycle.
- auto_mode  in  1  1 = round-robin distribution; in_sel ignored.
- out_data  out  NUM_CH*DATA_W  flattened channel bytes; channel k at bits [k*8+7:k*8].
- out_valid  out  NUM_CH  per-channel valid.
- out_ready  in  NUM_CH  per-channel consumer ready.
- err_sel  out  1  one-cycle pulse: byte dropped because of an invalid select.
- drop_count  out  CNT_W  saturating count of dropped bytes.
- rr_ptr  out  SEL_W  current round-robin target (0..4), for debug.

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, err_sel=0, drop_count=0, rr_ptr=0. The reset state applies immediately. In-flight and held bytes are discarded.
- Target selection:
  - auto_mode=1: target=rr_ptr.
  - auto_mode=0: target=in_sel.
  - Invalid target means manual mode with in_sel>4.
- in_ready is combinational:
  - 1 if the target is invalid;
  - otherwise ~out_valid[t] | out_ready[t], where t is the target (pass-through refill allowed).
- Accept happens when in_valid & in_ready.
  - Valid target: slot t loads in_data, and out_valid[t]=1 on the next cycle. Latency is 1 cycle; the other slots are untouched.
  - Invalid target: byte discarded, err_sel=1 on the next cycle for exactly one cycle, drop_count increments and saturates at 255.
- Output handshake: out_valid[k] & out_ready[k] consumes the byte.
  - The slot clears next cycle unless it is refilled in the same cycle; then out_valid stays 1 with the new data.
  - out_data[k] holds its last value while out_valid[k]=0.
- Round-robin pointer:
  - Increments on each accept in auto mode, wrapping 4->0.
  - Holds when there is no accept.
  - Clears synchronously to 0 on any cycle with auto_mode=0.
  - A toggle of auto_mode takes effect on the same cycle's target computation.
- Auto-mode stall: if slot rr_ptr is full and not being consumed, in_ready=0. No skipping to a free channel; ordering is strict.
- Simultaneous events: an accept into slot k and a consume from slot k in the same cycle produces a net refill. Consumes on other slots are independent.
- in_data and in_sel are ignored when in_valid=0.

Decomposition:
- Package demux5_pkg:
  - DATA_W, NUM_CH, SEL_W, CNT_W;
  - channel constants CH_A=0 .. CH_E=4;
  - function sel_is_valid(sel) returning sel<NUM_CH.
- Sub-module demux_slot: one-entry holding register with load/consume/valid logic. Instantiated NUM_CH times via generate.
- Top level: target mux, in_ready, round-robin pointer, error/drop logic.

Test Plan:
- Reset, then manual in_sel=2, data=0xA5, all out_ready=0 -> next cycle out_valid=00100 and channel C=0xA5; a second byte to C gives in_ready=0 until out_ready[2]=1.
- Manual in_sel=6, data=0x11 -> in_ready=1; err_sel pulses one cycle; drop_count=1; out_valid unchanged. 300 invalid bytes -> drop_count=255.
- auto_mode=1, bytes 0x10..0x16 with out_ready=all 1 -> channels receive A=0x10, B=0x11, C=0x12, D=0x13, E=0x14, A=0x15, B=0x16; rr_ptr wraps 4->0.
- Auto mode with out_ready[1]=0 and B full -> in_ready=0 while rr_ptr=1; release out_ready[1] -> the byte is accepted that cycle (pass-through) and rr_ptr=2 next cycle.
- Slot D full with out_valid=1 and out_ready[3]=1, new byte 0x7E sent to D in the same cycle -> out_valid[3] stays 1 and out_data D=0x7E next cycle.
- Assert rst asynchronously mid-stream with several slots full -> out_valid=0, out_data=0, drop_count=0 and rr_ptr=0 without waiting for a clock edge.
